// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb
// -----------------------------------------------------------------------------
// Round-robin arbiter that shares the write side of the async FIFO
// (w_push / w_data / w_full) among NUM_REQ requesters. One requester owns the
// port for a whole burst. The burst ends on that requester's last beat or after
// MAX_BURST beats, whichever comes first. Every burst is followed by one IDLE
// cycle, which is where the next owner is chosen. Everything runs in the write
// clock domain.
//
// Handshake: a requester beat transfers in a cycle where req_valid[i] and
// req_ready[i] are both high. req_ready[i] is high only while i owns the port
// and w_full is low, and it does not depend on req_valid[i]. A requester must
// hold req_valid, req_last and its data stable until the beat transfers.
// w_push goes high exactly for those transfers, so the FIFO is never pushed
// while w_full is high.
//
// Ports
//   w_clk      write-domain clock, all state changes on the rising edge
//   w_rst      asynchronous active-high reset
//   req_valid  per-requester beat valid
//   req_last   per-requester end-of-burst flag, qualified by req_valid
//   req_data   requester i drives bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  per-requester accept
//   w_full     FIFO full flag (registered in the FIFO)
//   w_push     FIFO write strobe
//   w_data     FIFO write data
//   grant      registered one-hot owner, zero when idle
//   busy       high while a burst is in progress (FSM state XFER)
// -----------------------------------------------------------------------------
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                          w_clk,
  input  logic                          w_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          w_full,
  output logic                          w_push,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  // One extra bit so that rr_ptr + offset can be wrapped without overflow.
  localparam int SUM_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] TOP_PTR   = PTR_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t             state, state_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_d;

  logic               sel_found;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W-1:0]   owner_idx;
  logic               owner_last;
  logic               burst_end;

  // The FSM state is visible outside the block as busy.
  assign busy = (state == XFER);

  // Search upward from rr_ptr for the first valid requester, wrapping at NUM_REQ.
  always_comb begin
    logic [SUM_W-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + SUM_W'(i);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      if (!sel_found && req_valid[cand[PTR_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Owner decode and write-data mux. grant is zero outside XFER, so the
  // AND-OR mux also gives w_data = 0 whenever the block is idle or in reset.
  always_comb begin
    owner_idx  = '0;
    owner_last = 1'b0;
    w_data     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        owner_idx = owner_idx | PTR_W'(i);
      end
      owner_last = owner_last | (grant[i] & req_last[i]);
      w_data     = w_data | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
    end
  end

  assign req_ready = grant & {NUM_REQ{~w_full}};
  assign w_push    = (|(grant & req_valid)) & ~w_full;
  assign burst_end = w_push & (owner_last | (beat_cnt == LAST_BEAT));

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      rr_ptr   <= rr_ptr_d;
      beat_cnt <= beat_cnt_d;
    end
  end

  // Next-state logic. While w_full is high in XFER there is no push, so
  // state, count and grant all hold. If the owner drops req_valid mid-burst
  // the grant is held too; the burst ends only on a last beat or MAX_BURST.
  always_comb begin
    state_d    = state;
    grant_d    = grant;
    rr_ptr_d   = rr_ptr;
    beat_cnt_d = beat_cnt;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_d          = XFER;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          beat_cnt_d       = '0;
        end
      end
      XFER: begin
        if (w_push) begin
          beat_cnt_d = beat_cnt + 1'b1;
          if (burst_end) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = (owner_idx == TOP_PTR) ? '0 : owner_idx + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Testbench for fifo_wr_arb (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=8).
// A table of per-cycle vectors covers the reset state, a single burst,
// round-robin order, backpressure and the burst limit. Hand-written sequences
// cover reset in the middle of a burst and fairness under saturation.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic           w_clk = 1'b0;
  logic           w_rst;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           w_full;
  logic           w_push;
  logic [DW-1:0]  w_data;
  logic [NR-1:0]  grant;
  logic           busy;

  always #5 w_clk = ~w_clk;

  fifo_wr_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
    .w_clk     (w_clk),
    .w_rst     (w_rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .w_full    (w_full),
    .w_push    (w_push),
    .w_data    (w_data),
    .grant     (grant),
    .busy      (busy)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int check_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string         name;
    logic          rst;
    logic [NR-1:0] valid;
    logic [NR-1:0] last;
    logic          full;
    logic [7:0]    dat;
    logic [NR-1:0] exp_grant;
    logic          exp_busy;
    logic          exp_push;
    logic [DW-1:0] exp_data;
    logic [NR-1:0] exp_ready;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic rst, input logic [NR-1:0] val,
                     input logic [NR-1:0] lst, input logic full, input logic [7:0] dat,
                     input logic [NR-1:0] g, input logic b, input logic p,
                     input logic [DW-1:0] d, input logic [NR-1:0] r);
    vec_t v;
    v.name = n; v.rst = rst; v.valid = val; v.last = lst; v.full = full; v.dat = dat;
    v.exp_grant = g; v.exp_busy = b; v.exp_push = p; v.exp_data = d; v.exp_ready = r;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  // Requester i drives {i, 16'h0, dat} so the owner is visible in w_data.
  task automatic drive(input logic rst, input logic [NR-1:0] val, input logic [NR-1:0] lst,
                       input logic full, input logic [7:0] dat);
    w_rst     = rst;
    req_valid = val;
    req_last  = lst;
    w_full    = full;
    for (int i = 0; i < NR; i++) begin
      req_data[i*DW +: DW] = {8'(i), 16'h0000, dat};
    end
  endtask

  task automatic check_idle(input string n);
    check({n, " grant"}, 32'(grant), 32'h0);
    check({n, " busy"}, 32'(busy), 32'h0);
    check({n, " push"}, 32'(w_push), 32'h0);
    check({n, " data"}, w_data, 32'h0);
    check({n, " ready"}, 32'(req_ready), 32'h0);
  endtask

  // fairness bookkeeping
  int fb_beat [NR];
  int fb_cnt  [NR];
  int fb_wait [NR];
  int exp_owner;
  int dut_owner;
  int bursts;
  int max_wait;

  initial begin
    w_rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 8'h00);
    #2 w_rst = 1'b1;

    // reset and single burst from req 2
    add("rst",      1, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 32'h0, 4'b0000);
    add("idle",     0, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 32'h0, 4'b0000);
    add("sb.arb",   0, 4'b0100, 4'b0000, 0, 8'hA0, 4'b0000, 0, 0, 32'h0, 4'b0000);
    add("sb.b0",    0, 4'b0100, 4'b0000, 0, 8'hA0, 4'b0100, 1, 1, 32'h020000A0, 4'b0100);
    add("sb.b1",    0, 4'b0100, 4'b0000, 0, 8'hA1, 4'b0100, 1, 1, 32'h020000A1, 4'b0100);
    add("sb.b2",    0, 4'b0100, 4'b0100, 0, 8'hA2, 4'b0100, 1, 1, 32'h020000A2, 4'b0100);
    add("sb.done",  0, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 32'h0, 4'b0000);
    // round robin between reqs 0 and 3, starting from rr_ptr = 0
    add("rr.rst",   1, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 32'h0, 4'b0000);
    add("rr.idle",  0, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 32'h0, 4'b0000);
    add("rr.arb",   0, 4'b1001, 4'b1001, 0, 8'hB0, 4'b0000, 0, 0, 32'h0, 4'b0000);
    add("rr.g0a",   0, 4'b1001, 4'b1001, 0, 8'hB0, 4'b0001, 1, 1, 32'h000000B0, 4'b0001);
    add("rr.gap1",  0, 4'b1001, 4'b1001, 0, 8'hB1, 4'b0000, 0, 0, 32'h0, 4'b0000);
    add("rr.g3a",   0, 4'b1001, 4'b1001, 0, 8'hB1, 4'b1000, 1, 1, 32'h030000B1, 4'b1000);
    add("rr.gap2",  0, 4'b1001, 4'b1001, 0, 8'hB2, 4'b0000, 0, 0, 32'h0, 4'b0000);
    add("rr.g0b",   0, 4'b1001, 4'b1001, 0, 8'hB3, 4'b0001, 1, 1, 32'h000000B3, 4'b0001);
    add("rr.gap3",  0, 4'b1001, 4'b1001, 0, 8'hB4, 4'b0000, 0, 0, 32'h0, 4'b0000);
    add("rr.g3b",   0, 4'b1001, 4'b1001, 0, 8'hB5, 4'b1000, 1, 1, 32'h030000B5, 4'b1000);
    add("rr.done",  0, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 32'h0, 4'b0000);
    // backpressure on req 1, w_full high for 3 cycles while beat 2 is offered
    add("bp.arb",   0, 4'b0010, 4'b0000, 0, 8'hC0, 4'b0000, 0, 0, 32'h0, 4'b0000);
    add("bp.b0",    0, 4'b0010, 4'b0000, 0, 8'hC0, 4'b0010, 1, 1, 32'h010000C0, 4'b0010);
    add("bp.full1", 0, 4'b0010, 4'b0000, 1, 8'hC1, 4'b0010, 1, 0, 32'h010000C1, 4'b0000);
    add("bp.full2", 0, 4'b0010, 4'b0000, 1, 8'hC1, 4'b0010, 1, 0, 32'h010000C1, 4'b0000);
    add("bp.full3", 0, 4'b0010, 4'b0000, 1, 8'hC1, 4'b0010, 1, 0, 32'h010000C1, 4'b0000);
    add("bp.b1",    0, 4'b0010, 4'b0000, 0, 8'hC1, 4'b0010, 1, 1, 32'h010000C1, 4'b0010);
    add("bp.b2",    0, 4'b0010, 4'b0000, 0, 8'hC2, 4'b0010, 1, 1, 32'h010000C2, 4'b0010);
    add("bp.b3",    0, 4'b0010, 4'b0010, 0, 8'hC3, 4'b0010, 1, 1, 32'h010000C3, 4'b0010);
    add("bp.done",  0, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 32'h0, 4'b0000);
    // burst limit: rr_ptr = 2, req 0 streams without last, req 1 waiting
    add("bl.arb",   0, 4'b0011, 4'b0000, 0, 8'hD0, 4'b0000, 0, 0, 32'h0, 4'b0000);
    for (int b = 0; b < 8; b++) begin
      add($sformatf("bl.b%0d", b), 0, 4'b0011, 4'b0000, 0, 8'hD0 + 8'(b),
          4'b0001, 1, 1, {24'h000000, 8'hD0 + 8'(b)}, 4'b0001);
    end
    add("bl.gap",   0, 4'b0011, 4'b0000, 0, 8'hD8, 4'b0000, 0, 0, 32'h0, 4'b0000);
    add("bl.g1",    0, 4'b0011, 4'b0010, 0, 8'hD8, 4'b0010, 1, 1, 32'h010000D8, 4'b0010);
    add("bl.done",  0, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 32'h0, 4'b0000);

    foreach (vecs[n]) begin
      @(negedge w_clk);
      drive(vecs[n].rst, vecs[n].valid, vecs[n].last, vecs[n].full, vecs[n].dat);
      #1;
      check({vecs[n].name, " grant"}, 32'(grant), 32'(vecs[n].exp_grant));
      check({vecs[n].name, " busy"}, 32'(busy), 32'(vecs[n].exp_busy));
      check({vecs[n].name, " push"}, 32'(w_push), 32'(vecs[n].exp_push));
      check({vecs[n].name, " data"}, w_data, vecs[n].exp_data);
      check({vecs[n].name, " ready"}, 32'(req_ready), 32'(vecs[n].exp_ready));
    end

    // ---------------- reset in the middle of a burst ----------------
    // First a 1-beat burst from req 2 moves rr_ptr from 2 to 3, so a
    // post-reset grant to req 2 shows that rr_ptr really returned to 0.
    @(negedge w_clk); drive(0, 4'b0100, 4'b0100, 0, 8'hE0);
    @(negedge w_clk); #1 check("mb.one push", 32'(w_push), 32'h1);
    @(negedge w_clk); drive(0, 4'b0000, 4'b0000, 0, 8'h00);
    @(negedge w_clk); drive(0, 4'b0100, 4'b0000, 0, 8'hE1);
    @(negedge w_clk); #1;
    check("mb.grant", 32'(grant), 32'h4);
    check("mb.b1 push", 32'(w_push), 32'h1);
    @(negedge w_clk); drive(0, 4'b0100, 4'b0000, 0, 8'hE2); #1;
    check("mb.b2 offered", 32'(w_push), 32'h1);
    #2 w_rst = 1'b1;
    #1 check_idle("mb.async");
    @(negedge w_clk); drive(1, 4'b1100, 4'b0000, 0, 8'hE2); #1;
    check_idle("mb.held");
    @(negedge w_clk); drive(0, 4'b1100, 4'b0000, 0, 8'hE2); #1;
    check_idle("mb.release");
    @(negedge w_clk); #1;
    check("mb.post grant", 32'(grant), 32'h4);
    check("mb.post data", w_data, 32'h020000E2);

    // ---------------- fairness under saturation ----------------
    @(negedge w_clk); drive(1, 4'b0000, 4'b0000, 0, 8'h00);
    @(negedge w_clk); drive(0, 4'b0000, 4'b0000, 0, 8'h00);
    for (int i = 0; i < NR; i++) begin
      fb_beat[i] = 0; fb_cnt[i] = 0; fb_wait[i] = 0;
    end
    exp_owner = 0; bursts = 0; max_wait = 0;
    for (int cyc = 0; cyc < 1000 && bursts < 100; cyc++) begin
      @(negedge w_clk);
      w_rst     = 1'b0;
      w_full    = 1'b0;
      req_valid = '1;
      for (int i = 0; i < NR; i++) begin
        req_last[i]          = (fb_beat[i] == 1);
        req_data[i*DW +: DW] = {8'(i), 16'h0000, 8'(fb_beat[i])};
      end
      #1;
      if (w_push) begin
        dut_owner = 0;
        for (int i = 0; i < NR; i++) if (grant[i]) dut_owner = i;
        check($sformatf("fair.grant b%0d", bursts), 32'(grant), 32'(1 << exp_owner));
        check($sformatf("fair.data b%0d", bursts), w_data,
              {8'(exp_owner), 16'h0000, 8'(fb_beat[exp_owner])});
        if (fb_beat[dut_owner] == 0) begin
          fb_cnt[dut_owner]++;
          if (fb_wait[dut_owner] > max_wait) max_wait = fb_wait[dut_owner];
          for (int i = 0; i < NR; i++) fb_wait[i] = (i == dut_owner) ? 0 : fb_wait[i] + 1;
          fb_beat[dut_owner] = 1;
        end else begin
          fb_beat[dut_owner] = 0;
          bursts++;
          exp_owner = (exp_owner + 1) % NR;
        end
      end
    end
    check("fair.bursts done", 32'(bursts), 32'd100);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("fair.count r%0d", i), 32'(fb_cnt[i]), 32'd25);
    end
    check("fair.max wait <= 3", 32'(max_wait <= 3), 32'h1);

    @(negedge w_clk); drive(0, 4'b0000, 4'b0000, 0, 8'h00);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-port arbiter placed in front of the async FIFO's write side. It shares the single `w_push`/`w_data`/`w_full` port among `NUM_REQ` requesters, granting the port to one requester for a whole burst. A burst ends on the requester's `last` beat or after `MAX_BURST` beats, whichever comes first. The block runs entirely in the write clock domain and never pushes while `w_full` is high.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥2.
- `DATA_WIDTH`, 32: FIFO data width.
- `MAX_BURST`, 8: maximum beats per grant; must be ≥1.
- `w_clk`  input  1  write-domain clock; all state changes on the rising edge.
- `w_rst`  input  1  asynchronous, active-high reset.
- `req_valid`  input  NUM_REQ  per-requester beat valid.
- `req_last`  input  NUM_REQ  per-requester end-of-burst flag, qualified by valid.
- `req_data`  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  output  NUM_REQ  beat accepted when valid & ready.
- `w_full`  input  1  FIFO full flag (write domain).
- `w_push`  output  1  FIFO write strobe.
- `w_data`  output  DATA_WIDTH  FIFO write data.
- `grant`  output  NUM_REQ  one-hot current owner, registered; all-zero when idle.
- `busy`  output  1  high while in XFER.

## Operation
- States:
  - IDLE (reset state).
  - XFER.
- Registers:
  - `state`.
  - `grant` (one-hot).
  - `rr_ptr` (index, clog2(NUM_REQ) bits).
  - `beat_cnt` (clog2(MAX_BURST)+1 bits).
- IDLE:
  - If any `req_valid` is high, select the first set bit searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - Load `grant` one-hot for that requester, clear `beat_cnt`, and go to XFER.
  - If no `req_valid` is high, remain in IDLE.
  - No beat is accepted in IDLE.
- XFER, owner k:
  - `req_ready[k]` = ~`w_full`; all other `req_ready` = 0.
  - `w_push` = `req_valid[k]` & ~`w_full`.
  - `w_data` = `req_data[k]`, driven combinationally from the `grant` mux.
  - `beat_cnt` increments on each `w_push`.
- Burst end: a `w_push` with `req_last[k]`=1, or a `w_push` with `beat_cnt` = MAX_BURST-1. On burst end:
  - Next state is IDLE.
  - `grant` clears to 0.
  - `rr_ptr` = (k+1) mod NUM_REQ.
- Owner drops `req_valid` mid-burst: the grant is held and XFER stays; no timeout other than MAX_BURST.
- `w_full` high in XFER: `w_push`=0, `req_ready`=0, and state, count and grant all hold.
- Outside XFER: `w_push`=0, `req_ready`=0, `w_data`=0.
- Reset values (async on `w_rst` rising, held while high):
  - state IDLE, `grant`=0, `rr_ptr`=0, `beat_cnt`=0.
  - Outputs: `busy`=0, `w_push`=0, `req_ready`=0, `w_data`=0.
- Reset mid-burst:
  - The beat in flight is not pushed; the requester must re-issue it.
  - After reset deasserts, arbitration restarts from requester 0.

## Timing
- Arbitration latency: 1 cycle. With `req_valid` rising in cycle n while idle, `grant` and `busy` are visible in n+1, and the first push can occur in n+1.
- One mandatory IDLE bubble cycle between consecutive bursts; peak throughput is MAX_BURST/(MAX_BURST+1).
- `w_push` follows `w_full` combinationally in the same cycle. The FIFO's `w_full` is a registered flag, so no combinational loop exists.
- The requester's data path to `w_data` is combinational: one mux level in the same cycle.

## Test plan
- **Single burst.**
  - Stimulus: after reset, req 2 holds valid with data 0xA0, 0xA1, 0xA2; last on the third beat; `w_full`=0.
  - Response: `grant`=4'b0100 one cycle after valid; 3 consecutive `w_push` with the same data; then `grant`=0 and `busy`=0.
- **Round-robin order.**
  - Stimulus: reqs 0 and 3 continuously valid, 1-beat bursts (last=1), `rr_ptr`=0.
  - Response: grants alternate 0,3,0,3 with one idle cycle between each.
- **Backpressure.**
  - Stimulus: req 1 bursts 4 beats; `w_full` is high in the cycle beat 2 is offered and stays high for 3 cycles.
  - Response: `w_push` and `req_ready[1]` stay 0 for those 3 cycles; beat 2 is pushed once `w_full` falls; exactly 4 pushes total, in order.
- **Burst limit.**
  - Stimulus: MAX_BURST=8; req 0 streams with last=0 while req 1 is also valid.
  - Response: exactly 8 pushes from req 0, then an IDLE cycle, then `grant`=4'b0010.
- **Reset mid-burst.**
  - Stimulus: assert `w_rst` asynchronously after beat 1 of a 4-beat burst from req 2.
  - Response: `w_push`, `grant` and `busy` go to 0 immediately without waiting for a clock edge. After release with reqs 2 and 3 valid, req 2 is granted first because `rr_ptr`=0.
- **Fairness under saturation.**
  - Stimulus: all 4 reqs valid with 2-beat bursts for 100 bursts.
  - Response: grant counts per requester are equal (25 each) and no requester waits more than 3 bursts.
